// File: rtl/holly_bus_pkg.sv
// Shared types and default region map for the HOLLY-side bus decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package holly_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_N_REGIONS = 4;
    localparam int DEF_ADDR_W    = 29;

    // Region 0 PVR regs, 1 TA regs, 2 VRAM64, 3 SDRAM (region 0 in the low bits).
    localparam logic [DEF_N_REGIONS*DEF_ADDR_W-1:0] DEF_BASE = {
        29'h0c00_0000, 29'h0400_0000, 29'h005f_8000, 29'h005f_7c00
    };
    localparam logic [DEF_N_REGIONS*DEF_ADDR_W-1:0] DEF_LIMIT = {
        29'h0cff_ffff, 29'h047f_ffff, 29'h005f_9fff, 29'h005f_7cff
    };

    // Fill bit replicated across the data width for error reads.
    localparam logic ERR_FILL = 1'b1;

endpackage

// File: rtl/holly_region_match.sv
// Range compare of an address against a base/limit table, lowest index wins.
// Latency: combinational.
// Backpressure: none (pure function of the address).
module holly_region_match #(
    parameter int                            N_REGIONS = 4,
    parameter int                            ADDR_W    = 29,
    parameter int                            IDX_W     = 2,
    parameter logic [N_REGIONS*ADDR_W-1:0]   BASE      = '0,
    parameter logic [N_REGIONS*ADDR_W-1:0]   LIMIT     = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Walk from the highest index down so the lowest matching region is the last writer.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((addr >= BASE[i*ADDR_W +: ADDR_W]) && (addr <= LIMIT[i*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/holly_bus_decoder.sv
// SH4 data port to N HOLLY targets: decode, forward with rebased address, return one muxed response.
// Latency: miss 1 cycle after accept; hit 2 cycles after accept plus target wait/response cycles.
// Backpressure: one transaction in flight; cpu_req_ready only in IDLE. HOLLY_BUS_TIMEOUT_EN adds a stall watchdog.
module holly_bus_decoder
    import holly_bus_pkg::*;
#(
    parameter int                           N_REGIONS      = 4,
    parameter int                           ADDR_W         = 29,
    parameter int                           DATA_W         = 64,
    parameter logic [N_REGIONS*ADDR_W-1:0]  REGION_BASE    = holly_bus_pkg::DEF_BASE,
    parameter logic [N_REGIONS*ADDR_W-1:0]  REGION_LIMIT   = holly_bus_pkg::DEF_LIMIT,
    parameter logic [N_REGIONS-1:0]         REGION_NARROW  = 4'b0011,
    parameter int                           TIMEOUT_CYCLES = 256
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          cpu_req_valid,
    output logic                          cpu_req_ready,
    input  logic [ADDR_W-1:0]             cpu_req_addr,
    input  logic [DATA_W-1:0]             cpu_req_wdata,
    input  logic [DATA_W/8-1:0]           cpu_req_wmask,
    input  logic                          cpu_req_wen,
    output logic                          cpu_resp_valid,
    output logic [DATA_W-1:0]             cpu_resp_rdata,
    output logic                          cpu_resp_err,
    output logic [N_REGIONS-1:0]          tgt_req_valid,
    input  logic [N_REGIONS-1:0]          tgt_req_ready,
    output logic [ADDR_W-1:0]             tgt_req_addr,
    output logic [DATA_W-1:0]             tgt_req_wdata,
    output logic [DATA_W/8-1:0]           tgt_req_wmask,
    output logic                          tgt_req_wen,
    input  logic [N_REGIONS-1:0]          tgt_resp_valid,
    input  logic [N_REGIONS*DATA_W-1:0]   tgt_resp_rdata
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int HALF  = DATA_W / 2;

    if ((N_REGIONS < 1) || (N_REGIONS > 16) || (TIMEOUT_CYCLES < 2)) begin : g_bad_cfg
        $error("holly_bus_decoder: N_REGIONS must be 1..16 and TIMEOUT_CYCLES >= 2");
    end

    state_t              state, state_nxt;
    logic                ready_en_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [ADDR_W-1:0]   hit_base;
    logic                accept;
    logic                sel_ready;
    logic                sel_resp;
    logic [DATA_W-1:0]   sel_rdata;
    logic                resp_fire;
    logic                timeout_hit;

    holly_region_match #(
        .N_REGIONS (N_REGIONS),
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W),
        .BASE      (REGION_BASE),
        .LIMIT     (REGION_LIMIT)
    ) u_match (
        .addr (cpu_req_addr),
        .hit  (hit),
        .idx  (hit_idx)
    );

    assign hit_base  = REGION_BASE[int'(hit_idx)*ADDR_W +: ADDR_W];
    assign accept    = cpu_req_valid && cpu_req_ready;
    // Only the latched target's inputs are ever looked at.
    assign sel_ready = tgt_req_ready[idx_q];
    assign sel_resp  = tgt_resp_valid[idx_q];
    assign sel_rdata = tgt_resp_rdata[int'(idx_q)*DATA_W +: DATA_W];
    assign resp_fire = ((state == ST_REQ) && sel_ready && sel_resp) ||
                       ((state == ST_RESP) && sel_resp);

`ifdef HOLLY_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    // Watchdog: cleared on accept, counts every cycle spent waiting on the target.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if ((state == ST_REQ) || (state == ST_RESP)) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // Fires in the last waiting cycle so the error response lands TIMEOUT_CYCLES after the request.
    assign timeout_hit = ((state == ST_REQ) || (state == ST_RESP)) &&
                         (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: a stalled target holds the decoder until reset.
    assign timeout_hit = 1'b0;
`endif

    // Ready is held low until the first clock after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a real response in the final watchdog cycle still completes normally.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = hit ? ST_REQ : ST_DONE;
            ST_REQ: begin
                if (resp_fire || timeout_hit) state_nxt = ST_DONE;
                else if (sel_ready)           state_nxt = ST_RESP;
            end
            ST_RESP: if (resp_fire || timeout_hit) state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request payload capture on accept, response data/error capture on completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q         <= '0;
            tgt_req_addr  <= '0;
            tgt_req_wdata <= '0;
            tgt_req_wmask <= '0;
            tgt_req_wen   <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else if (accept) begin
            idx_q         <= hit_idx;
            tgt_req_addr  <= hit ? (cpu_req_addr - hit_base) : '0;
            tgt_req_wdata <= cpu_req_wdata;
            tgt_req_wmask <= cpu_req_wmask;
            tgt_req_wen   <= cpu_req_wen;
            err_q         <= ~hit;
            rdata_q       <= (!hit && !cpu_req_wen) ? {DATA_W{ERR_FILL}} : '0;
        end else if (resp_fire) begin
            err_q <= 1'b0;
            if (tgt_req_wen)               rdata_q <= '0;
            else if (REGION_NARROW[idx_q]) rdata_q <= {{(DATA_W-HALF){1'b0}}, sel_rdata[HALF-1:0]};
            else                           rdata_q <= sel_rdata;
        end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= tgt_req_wen ? '0 : {DATA_W{ERR_FILL}};
        end
    end

    // One-hot request toward the latched target while in REQ.
    always_comb begin
        tgt_req_valid = '0;
        if (state == ST_REQ) tgt_req_valid[idx_q] = 1'b1;
    end

    assign cpu_req_ready  = (state == ST_IDLE) && ready_en_q;
    assign cpu_resp_valid = (state == ST_DONE);
    assign cpu_resp_rdata = (state == ST_DONE) ? rdata_q : '0;
    assign cpu_resp_err   = (state == ST_DONE) && err_q;

endmodule
